// File: rtl/vga_pkg.sv
// Shared raster timing constants and coordinate type
// for the VGA sync generator.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int h_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Clock-enable qualified shift register; the output is the
// input as it was DEPTH enabled advances ago.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_pix,
  input  logic             resetn,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] sr [DEPTH];

      always_ff @(posedge clk_pix) begin
        if (!resetn) begin
          for (int i = 0; i < DEPTH; i++)
            sr[i] <= RST_VAL;
        end else if (ce) begin
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++)
            sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: counters, registered next-position
// decode of de/syncs, line/frame strobes and a realign delay.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic   clk_pix,
  input  logic   resetn,
  input  logic   ce,
  output coord_t hcount,
  output coord_t vcount,
  output logic   de,
  output logic   hsync,
  output logic   vsync,
  output logic   line_start,
  output logic   frame_start,
  output logic   de_d,
  output logic   hsync_d,
  output logic   vsync_d
);

  localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  coord_t h_nxt;
  coord_t v_nxt;
  logic   h_wrap;
  logic   v_wrap;
  logic   de_nxt;
  logic   hs_nxt;
  logic   vs_nxt;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_nxt  = h_wrap ? '0 : hcount + coord_t'(1);
    v_nxt  = vcount;
    if (h_wrap)
      v_nxt = v_wrap ? '0 : vcount + coord_t'(1);
  end

  // Decode the position being entered so outputs align with the counters.
  always_comb begin
    de_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt = (h_nxt >= HS_BEG && h_nxt <= HS_END) ? HS_POL : ~HS_POL;
    vs_nxt = (v_nxt >= VS_BEG && v_nxt <= VS_END) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        hcount      <= h_nxt;
        vcount      <= v_nxt;
        de          <= de_nxt;
        hsync       <= hs_nxt;
        vsync       <= vs_nxt;
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
  ) u_dly (
    .clk_pix (clk_pix),
    .resetn  (resetn),
    .ce      (ce),
    .d       ({de, hsync, vsync}),
    .q       ({de_d, hsync_d, vsync_d})
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a shrunken raster
// so several whole frames fit in a short run.
module tb_vga_sync_gen;
  import vga_pkg::*;

  localparam int HA = 16, HFP = 2, HSW = 4, HBP = 3;
  localparam int VA = 6, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int DLY = 2;

  logic   clk_pix = 1'b0;
  logic   resetn = 1'b0;
  logic   ce = 1'b0;
  coord_t hcount, vcount;
  logic   de, hsync, vsync, line_start, frame_start;
  logic   de_d, hsync_d, vsync_d;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(DLY)
  ) dut (
    .clk_pix(clk_pix), .resetn(resetn), .ce(ce),
    .hcount(hcount), .vcount(vcount), .de(de),
    .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .de_d(de_d), .hsync_d(hsync_d), .vsync_d(vsync_d)
  );

  always #5 clk_pix = ~clk_pix;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int mh, mv;
  bit m_ls, m_fs;
  bit [2:0] hist[$];
  int cyc = 0;
  int ls_last = -1, ls_gap = 0;
  int fs_last = -1, fs_gap = 0;

  // Reference view of one raster position: {de, hsync, vsync}.
  function automatic bit [2:0] trip(input int h, input int v);
    bit d, hs, vs;
    d  = (h < HA) && (v < VA);
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    return {d, hs, vs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (!resetn) begin
      mh = HT - 1;
      mv = VT - 1;
      m_ls = 0;
      m_fs = 0;
      hist = {3'b011, 3'b011};
    end else if (ce) begin
      hist.push_back(trip(mh, mv));
      void'(hist.pop_front());
      mh = mh + 1;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
      m_ls = (mh == 0);
      m_fs = (mh == 0) && (mv == 0);
    end else begin
      m_ls = 0;
      m_fs = 0;
    end
  endtask

  task automatic tick();
    bit [2:0] t;
    @(posedge clk_pix);
    model_step();
    #1;
    cyc++;
    t = trip(mh, mv);
    chk("hcount", 32'(hcount), 32'(mh));
    chk("vcount", 32'(vcount), 32'(mv));
    chk("de", 32'(de), 32'(t[2]));
    chk("hsync", 32'(hsync), 32'(t[1]));
    chk("vsync", 32'(vsync), 32'(t[0]));
    chk("line_start", 32'(line_start), 32'(m_ls));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("de_d", 32'(de_d), 32'(hist[0][2]));
    chk("hsync_d", 32'(hsync_d), 32'(hist[0][1]));
    chk("vsync_d", 32'(vsync_d), 32'(hist[0][0]));
    if (line_start === 1'b1) begin
      if (ls_last >= 0) ls_gap = cyc - ls_last;
      ls_last = cyc;
    end
    if (frame_start === 1'b1) begin
      if (fs_last >= 0) fs_gap = cyc - fs_last;
      fs_last = cyc;
    end
  endtask

  initial begin
    mh = HT - 1;
    mv = VT - 1;
    hist = {3'b011, 3'b011};

    // Reset holds even with ce toggling.
    resetn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ce = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_h", 32'(hcount), 32'(HT - 1));
    chk("rst_v", 32'(vcount), 32'(VT - 1));

    resetn = 1'b1;
    ce = 1'b1;
    tick();
    chk("first_h", 32'(hcount), 32'd0);
    chk("first_v", 32'(vcount), 32'd0);
    chk("first_de", 32'(de), 32'd1);
    chk("first_fs", 32'(frame_start), 32'd1);
    ce = 1'b0;
    tick();
    chk("ls_clear", 32'(line_start), 32'd0);

    // Free run for two frames plus a bit.
    ce = 1'b1;
    ls_last = -1;
    fs_last = -1;
    for (int i = 0; i < 2 * HT * VT + 5; i++) tick();
    chk("ls_period", 32'(ls_gap), 32'(HT));
    chk("fs_period", 32'(fs_gap), 32'(HT * VT));

    // ce one cycle in four.
    ls_last = -1;
    fs_last = -1;
    for (int i = 0; i < 4 * (2 * HT * VT + 5); i++) begin
      ce = (i % 4 == 0);
      tick();
    end
    chk("ls_period_ce4", 32'(ls_gap), 32'(4 * HT));
    chk("fs_period_ce4", 32'(fs_gap), 32'(4 * HT * VT));

    // Irregular ce exercises the delay line.
    for (int i = 0; i < 3000; i++) begin
      ce = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Mid-frame reset with ce held high.
    ce = 1'b1;
    for (int i = 0; i < HT * VT; i++) begin
      if (mh == 10 && mv == 4) break;
      tick();
    end
    chk("pre_rst_h", 32'(hcount), 32'd10);
    chk("pre_rst_v", 32'(vcount), 32'd4);
    resetn = 1'b0;
    tick();
    chk("mid_rst_h", 32'(hcount), 32'(HT - 1));
    chk("mid_rst_v", 32'(vcount), 32'(VT - 1));
    chk("mid_rst_de_d", 32'(de_d), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ce = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
